// File: rtl/wifi_tx_frame_builder.sv
// Wi-Fi TX frame builder: passes preamble samples straight through, then plays each
// buffered IFFT symbol out with its cyclic prefix from a pair of ping-pong buffers.
module wifi_tx_frame_builder #(
   parameter int SAMPLE_W = 12,
   parameter int N_FFT    = 64,
   parameter int CP_LEN   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          num_symbols,
   input  logic                pre_valid,
   input  logic [SAMPLE_W-1:0] pre_re,
   input  logic [SAMPLE_W-1:0] pre_im,
   input  logic                pre_done,
   input  logic                ifft_valid,
   input  logic [SAMPLE_W-1:0] ifft_re,
   input  logic [SAMPLE_W-1:0] ifft_im,
   output logic                ifft_ready,
   output logic                tx_valid,
   output logic [SAMPLE_W-1:0] tx_re,
   output logic [SAMPLE_W-1:0] tx_im,
   output logic                frame_done,
   output logic                overflow
);
   localparam int IDX_W = $clog2(N_FFT);
   localparam int CNT_W = $clog2(N_FFT + CP_LEN);

   typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DONE} state_t;

   state_t              state_q;
   logic [7:0]          nsym_q, acc_cnt_q, out_cnt_q;
   logic                wr_buf_q, rd_buf_q;
   logic [1:0]          full_q, full_d;
   logic [IDX_W-1:0]    wr_idx_q, rd_idx;
   logic [CNT_W-1:0]    rd_cnt_q;
   logic                tx_valid_q, frame_done_q, overflow_q;
   logic [SAMPLE_W-1:0] tx_re_q, tx_im_q;
   logic [SAMPLE_W-1:0] buf_re [2][N_FFT];
   logic [SAMPLE_W-1:0] buf_im [2][N_FFT];
   logic                accept, wr_last, rd_go, rd_last;

   assign ifft_ready = (state_q == DATA) && !full_q[wr_buf_q] && (acc_cnt_q < nsym_q);
   assign accept     = ifft_valid && ifft_ready;
   assign wr_last    = accept && (wr_idx_q == IDX_W'(N_FFT - 1));
   assign rd_go      = (state_q == DATA) && full_q[rd_buf_q];
   assign rd_last    = rd_go && (rd_cnt_q == CNT_W'(N_FFT + CP_LEN - 1));

   // Readout walks the cyclic prefix (tail of the symbol) first, then the whole symbol.
   // NOTE: combinational blocks use blocking '=' and assign every output on every path,
   // so no latch is inferred; clocked blocks use '<=' only.
   always_comb begin
      rd_idx = '0;
      if (rd_cnt_q < CNT_W'(CP_LEN)) rd_idx = IDX_W'(rd_cnt_q + CNT_W'(N_FFT - CP_LEN));
      else                           rd_idx = IDX_W'(rd_cnt_q - CNT_W'(CP_LEN));
   end

   // A buffer can complete on the write side while the other one is freed on the read side.
   always_comb begin
      full_d = full_q;
      if (wr_last) full_d[wr_buf_q] = 1'b1;
      if (rd_last) full_d[rd_buf_q] = 1'b0;
   end

   // NOTE: sample storage is deliberately left out of reset; the full flags decide what
   // is meaningful, which lets the buffers map onto plain RAM.
   always_ff @(posedge clk) begin
      if (accept) begin
         buf_re[wr_buf_q][wr_idx_q] <= ifft_re;
         buf_im[wr_buf_q][wr_idx_q] <= ifft_im;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         nsym_q       <= '0;
         acc_cnt_q    <= '0;
         out_cnt_q    <= '0;
         wr_buf_q     <= 1'b0;
         rd_buf_q     <= 1'b0;
         full_q       <= '0;
         wr_idx_q     <= '0;
         rd_cnt_q     <= '0;
         tx_valid_q   <= 1'b0;
         tx_re_q      <= '0;
         tx_im_q      <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         tx_valid_q   <= 1'b0;
         frame_done_q <= 1'b0;
         if (ifft_valid && !ifft_ready) overflow_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (start) begin
                  nsym_q    <= num_symbols;
                  acc_cnt_q <= '0;
                  out_cnt_q <= '0;
                  wr_buf_q  <= 1'b0;
                  rd_buf_q  <= 1'b0;
                  full_q    <= '0;
                  wr_idx_q  <= '0;
                  rd_cnt_q  <= '0;
                  state_q   <= PREAMBLE;
               end
            end

            PREAMBLE: begin
               if (pre_valid) begin
                  tx_valid_q <= 1'b1;
                  tx_re_q    <= pre_re;
                  tx_im_q    <= pre_im;
               end
               if (pre_done) state_q <= (nsym_q == 8'd0) ? DONE : DATA;
            end

            DATA: begin
               full_q <= full_d;
               if (accept) begin
                  wr_idx_q <= wr_idx_q + IDX_W'(1);
                  if (wr_last) begin
                     wr_buf_q  <= ~wr_buf_q;
                     acc_cnt_q <= acc_cnt_q + 8'd1;
                  end
               end
               if (rd_go) begin
                  tx_valid_q <= 1'b1;
                  tx_re_q    <= buf_re[rd_buf_q][rd_idx];
                  tx_im_q    <= buf_im[rd_buf_q][rd_idx];
                  rd_cnt_q   <= rd_last ? '0 : rd_cnt_q + CNT_W'(1);
                  if (rd_last) begin
                     rd_buf_q  <= ~rd_buf_q;
                     out_cnt_q <= out_cnt_q + 8'd1;
                     if (out_cnt_q + 8'd1 == nsym_q) state_q <= DONE;
                  end
               end
            end

            DONE: begin
               frame_done_q <= 1'b1;
               state_q      <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_valid   = tx_valid_q;
   assign tx_re      = tx_re_q;
   assign tx_im      = tx_im_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_wifi_tx_frame_builder.sv
// Directed bench for wifi_tx_frame_builder: a table of whole-frame scenarios plus a
// hand-written mid-readout reset sequence, all checked against a small sample model.
module tb_wifi_tx_frame_builder;
   localparam int SW  = 12;
   localparam int NF  = 64;
   localparam int CP  = 16;
   localparam int SYM = NF + CP;

   logic          clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [7:0]    num_symbols = '0;
   logic          pre_valid = 1'b0, pre_done = 1'b0, ifft_valid = 1'b0;
   logic [SW-1:0] pre_re = '0, pre_im = '0, ifft_re = '0, ifft_im = '0;
   logic          ifft_ready, tx_valid, frame_done, overflow;
   logic [SW-1:0] tx_re, tx_im;

   wifi_tx_frame_builder #(.SAMPLE_W(SW), .N_FFT(NF), .CP_LEN(CP)) dut (
      .clk(clk), .reset(reset), .start(start), .num_symbols(num_symbols),
      .pre_valid(pre_valid), .pre_re(pre_re), .pre_im(pre_im), .pre_done(pre_done),
      .ifft_valid(ifft_valid), .ifft_re(ifft_re), .ifft_im(ifft_im), .ifft_ready(ifft_ready),
      .tx_valid(tx_valid), .tx_re(tx_re), .tx_im(tx_im),
      .frame_done(frame_done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input longint got, input longint exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
   endtask

   // Monitor: samples outputs on the falling edge, well away from the active edge.
   int                cyc = 0;
   logic [2*SW-1:0]   tx_q[$];
   int                tx_cyc[$];
   int                fd_cnt = 0, fd_cyc = 0;
   bit                ready_seen = 1'b0, mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_en) begin
         if (tx_valid) begin
            tx_q.push_back({tx_re, tx_im});
            tx_cyc.push_back(cyc);
         end
         if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
         end
         if (ifft_ready) ready_seen = 1'b1;
      end
   end

   function automatic logic [2*SW-1:0] pre_model(input int k);
      logic [SW-1:0] r;
      r = SW'(k * 7 + 3);
      return {r, ~r};
   endfunction

   function automatic logic [2*SW-1:0] src_model(input logic [SW-1:0] base, input int n);
      logic [SW-1:0] r;
      r = base + SW'(n);
      return {r, r ^ 12'hA5A};
   endfunction

   // Output position j of the data section: symbol j/SYM, CP tail first, then 0..NF-1.
   function automatic logic [2*SW-1:0] data_model(input logic [SW-1:0] base, input int j);
      int s, p, idx;
      s   = j / SYM;
      p   = j % SYM;
      idx = (p < CP) ? (NF - CP + p) : (p - CP);
      return src_model(base, s * NF + idx);
   endfunction

   typedef struct {
      int            nsym;
      int            npre;
      logic [SW-1:0] base;
      bit            stall;
      bit            force_ovf;
      bit            start_mid;
      int            exp_tx;
      bit            exp_ovf;
      int            exp_drop;
      bit            exp_ready;
   } vec_t;

   vec_t vecs[6];

   task automatic apply_reset(input string tag);
      reset = 1'b1; start = 1'b0; pre_valid = 1'b0; pre_done = 1'b0; ifft_valid = 1'b0;
      repeat (2) @(negedge clk);
      check({tag, ".rst_tx_valid"}, tx_valid, 0);
      check({tag, ".rst_tx_data"}, {tx_re, tx_im}, 0);
      check({tag, ".rst_ifft_ready"}, ifft_ready, 0);
      check({tag, ".rst_frame_done"}, frame_done, 0);
      check({tag, ".rst_overflow"}, overflow, 0);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_frame(input vec_t v, input string tag, input bit do_reset,
                            input int abort_at, output bit aborted);
      int src, total, drop_at, acc0_cyc, pd_cyc, budget, bad, k, last;
      bit want;
      int pre_drv[$];
      aborted = 1'b0;
      if (do_reset) apply_reset(tag);
      tx_q.delete(); tx_cyc.delete();
      fd_cnt = 0; fd_cyc = 0; ready_seen = 1'b0; mon_en = 1'b1;

      // Stray preamble strobe in IDLE must be ignored.
      pre_valid = 1'b1; pre_re = 12'hBAD; pre_im = 12'hBAD;
      @(negedge clk);
      pre_valid = 1'b0; start = 1'b1; num_symbols = 8'(v.nsym);
      @(negedge clk);
      start = 1'b0; num_symbols = 8'hEE;
      for (int i = 0; i < v.npre; i++) begin
         pre_valid = 1'b1;
         {pre_re, pre_im} = pre_model(i);
         pre_drv.push_back(cyc);
         @(negedge clk);
      end
      pre_valid = 1'b0; pre_done = 1'b1; pd_cyc = cyc;
      @(negedge clk);
      pre_done = 1'b0;

      src = 0; total = v.nsym * NF; drop_at = -1; acc0_cyc = -1; budget = 0;
      while (fd_cnt == 0 && budget < 2000) begin
         if (abort_at > 0 && tx_q.size() >= abort_at) begin
            aborted = 1'b1;
            break;
         end
         start       = v.start_mid && (src == 10);
         num_symbols = 8'd99;
         pre_valid   = cyc[0]; pre_re = 12'hBAD; pre_im = 12'hBAD;
         if (drop_at < 0 && src > 0 && src < total && !ifft_ready) drop_at = src;
         want       = (src < total) && (!v.stall || cyc[0] == 1'b0);
         ifft_valid = v.force_ovf ? want : (want && ifft_ready);
         if (ifft_ready) {ifft_re, ifft_im} = src_model(v.base, src);
         else begin
            ifft_re = 12'hDEA; ifft_im = 12'hDEA;
         end
         if (ifft_valid && ifft_ready) begin
            if (src == NF - 1) acc0_cyc = cyc;
            src++;
         end
         @(negedge clk);
         budget++;
      end
      ifft_valid = 1'b0; pre_valid = 1'b0; start = 1'b0;
      if (aborted) begin
         mon_en = 1'b0;
         return;
      end
      repeat (3) @(negedge clk);
      mon_en = 1'b0;

      check({tag, ".tx_count"}, tx_q.size(), v.exp_tx);
      if (v.npre > 0 && tx_q.size() >= v.npre) begin
         bad = -1;
         for (int i = 0; i < v.npre; i++)
            if (bad < 0 && tx_q[i] !== pre_model(i)) bad = i;
         k = (bad < 0) ? v.npre - 1 : bad;
         check({tag, ".pre_value"}, tx_q[k], pre_model(k));
         check({tag, ".pre_lat_first"}, tx_cyc[0] - pre_drv[0], 1);
         check({tag, ".pre_lat_last"}, tx_cyc[v.npre-1] - pre_drv[v.npre-1], 1);
      end
      if (v.nsym > 0 && tx_q.size() == v.exp_tx) begin
         bad = -1;
         for (int j = 0; j < v.nsym * SYM; j++)
            if (bad < 0 && tx_q[v.npre+j] !== data_model(v.base, j)) bad = j;
         k = (bad < 0) ? v.nsym * SYM - 1 : bad;
         check({tag, ".data_value"}, tx_q[v.npre+k], data_model(v.base, k));
         check({tag, ".first_cp_lat"}, tx_cyc[v.npre] - acc0_cyc, 2);
         last = v.exp_tx - 1;
         if (!v.stall) check({tag, ".gapless"}, tx_cyc[last] - tx_cyc[v.npre], v.nsym * SYM - 1);
         check({tag, ".done_lat"}, fd_cyc - tx_cyc[last], 1);
      end
      if (v.nsym == 0) check({tag, ".done_lat"}, fd_cyc - pd_cyc, 2);
      check({tag, ".done_count"}, fd_cnt, 1);
      check({tag, ".overflow"}, overflow, v.exp_ovf);
      check({tag, ".ready_seen"}, ready_seen, v.exp_ready);
      check({tag, ".ready_drop_at"}, drop_at, v.exp_drop);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit aborted;
      bit stray;
      vecs[0] = '{nsym:1, npre:320, base:12'h000, stall:0, force_ovf:0, start_mid:0,
                  exp_tx:400, exp_ovf:0, exp_drop:-1, exp_ready:1};
      vecs[1] = '{nsym:3, npre:8,   base:12'h100, stall:0, force_ovf:0, start_mid:0,
                  exp_tx:248, exp_ovf:0, exp_drop:128, exp_ready:1};
      vecs[2] = '{nsym:0, npre:5,   base:12'h000, stall:0, force_ovf:0, start_mid:0,
                  exp_tx:5,   exp_ovf:0, exp_drop:-1, exp_ready:0};
      vecs[3] = '{nsym:2, npre:4,   base:12'hFC0, stall:1, force_ovf:0, start_mid:0,
                  exp_tx:164, exp_ovf:0, exp_drop:-1, exp_ready:1};
      vecs[4] = '{nsym:3, npre:6,   base:12'h300, stall:0, force_ovf:1, start_mid:0,
                  exp_tx:246, exp_ovf:1, exp_drop:128, exp_ready:1};
      vecs[5] = '{nsym:2, npre:3,   base:12'h050, stall:0, force_ovf:0, start_mid:1,
                  exp_tx:163, exp_ovf:0, exp_drop:-1, exp_ready:1};

      for (int r = 0; r < 6; r++)
         run_frame(vecs[r], $sformatf("row%0d", r), 1'b1, 0, aborted);

      // Reset in the middle of the second symbol's readout, then a clean frame.
      run_frame(vecs[1], "rst_mid", 1'b1, vecs[1].npre + SYM + 20, aborted);
      check("rst_mid.aborted", aborted, 1);
      check("rst_mid.busy", tx_valid, 1);
      #2 reset = 1'b1;
      #1;
      check("rst_mid.tx_valid", tx_valid, 0);
      check("rst_mid.tx_data", {tx_re, tx_im}, 0);
      check("rst_mid.ifft_ready", ifft_ready, 0);
      check("rst_mid.frame_done", frame_done, 0);
      @(negedge clk);
      reset = 1'b0;
      stray = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pre_valid = 1'b1;
         @(negedge clk);
         if (tx_valid || ifft_ready || frame_done) stray = 1'b1;
      end
      pre_valid = 1'b0;
      check("rst_mid.idle_hold", stray, 0);
      run_frame(vecs[3], "post_rst", 1'b0, 0, aborted);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
